// File: rtl/laser_tx_scheduler_pkg.sv
// Shared types and nibble helpers for the laser GPIO transmit path.
// The receiver uses the same header/checksum helpers to validate frames.
package laser_pkg;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_PRE  = 3'd1,
    S_HDR  = 3'd2,
    S_DHI  = 3'd3,
    S_DLO  = 3'd4,
    S_CHK  = 3'd5,
    S_GAP  = 3'd6
  } tx_state_t;

  localparam logic [1:0] HDR_TAG = 2'b01;

  function automatic logic [3:0] hdr_nibble(input logic ch_id, input logic [7:0] data);
    return {HDR_TAG, ch_id, ^data};
  endfunction

  function automatic logic [3:0] chk_nibble(input logic ch_id, input logic [7:0] data);
    return hdr_nibble(ch_id, data) ^ data[7:4] ^ data[3:0];
  endfunction

endpackage

// File: rtl/laser_tx_scheduler_rr_arbiter2.sv
// Combinational two-way round-robin grant; on contention the channel that
// did not win last time is chosen.
module rr_arbiter2 (
  input  logic [1:0] valid,
  input  logic       last_grant,
  output logic       grant_valid,
  output logic       grant
);

  always_comb begin
    grant_valid = |valid;
    grant       = (valid == 2'b11) ? ~last_grant : valid[1];
  end

endmodule

// File: rtl/laser_tx_scheduler.sv
// Round-robin scheduler serializing ch0/ch1 bytes into 5-nibble frames on the
// laser GPIO lane, followed by a fixed idle gap.
module laser_tx_scheduler
  import laser_pkg::*;
#(
  parameter int unsigned NIBBLE_CLKS = 2,
  parameter int unsigned GAP_CLKS    = 4,
  parameter logic [3:0]  PREAMBLE    = 4'hA
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        enable,
  input  logic [7:0]  ch0_data,
  input  logic        ch0_valid,
  output logic        ch0_ready,
  input  logic [7:0]  ch1_data,
  input  logic        ch1_valid,
  output logic        ch1_ready,
  output logic [3:0]  lane_out,
  output logic        busy,
  output logic        last_grant,
  output logic [15:0] frame_count
);

  localparam int unsigned MAXC = (NIBBLE_CLKS > GAP_CLKS) ? NIBBLE_CLKS : GAP_CLKS;
  localparam int unsigned CW   = (MAXC > 1) ? $clog2(MAXC) : 1;

  tx_state_t     state;
  tx_state_t     next_state;
  logic [CW-1:0] cnt;
  logic [7:0]    data_q;
  logic          ch_id;
  logic [3:0]    next_lane;
  logic          gnt_valid;
  logic          gnt;
  logic          grant_ok;
  logic          accept;
  logic          nib_done;
  logic          gap_done;

  rr_arbiter2 u_arb (
    .valid       ({ch1_valid, ch0_valid}),
    .last_grant  (last_grant),
    .grant_valid (gnt_valid),
    .grant       (gnt)
  );

  always_comb begin
    grant_ok  = (state == S_IDLE) & enable & ~reset & gnt_valid;
    ch0_ready = grant_ok & ~gnt;
    ch1_ready = grant_ok & gnt;
    accept    = (ch0_valid & ch0_ready) | (ch1_valid & ch1_ready);
    busy      = (state != S_IDLE);
    nib_done  = (cnt == CW'(NIBBLE_CLKS - 1));
    gap_done  = (cnt == CW'(GAP_CLKS - 1));
  end

  // Nibble to load into lane_out when the current nibble slot expires.
  always_comb begin
    next_state = S_IDLE;
    next_lane  = '0;
    unique case (state)
      S_PRE: begin
        next_state = S_HDR;
        next_lane  = hdr_nibble(ch_id, data_q);
      end
      S_HDR: begin
        next_state = S_DHI;
        next_lane  = data_q[7:4];
      end
      S_DHI: begin
        next_state = S_DLO;
        next_lane  = data_q[3:0];
      end
      S_DLO: begin
        next_state = S_CHK;
        next_lane  = chk_nibble(ch_id, data_q);
      end
      S_CHK: begin
        next_state = S_GAP;
        next_lane  = '0;
      end
      default: begin
        next_state = S_IDLE;
        next_lane  = '0;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= S_IDLE;
      lane_out    <= '0;
      last_grant  <= 1'b1;
      frame_count <= '0;
      cnt         <= '0;
      data_q      <= '0;
      ch_id       <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: begin
          lane_out <= '0;
          if (accept) begin
            data_q     <= gnt ? ch1_data : ch0_data;
            ch_id      <= gnt;
            last_grant <= gnt;
            state      <= S_PRE;
            lane_out   <= PREAMBLE;
            cnt        <= '0;
          end
        end
        S_GAP: begin
          if (gap_done) begin
            state <= S_IDLE;
            cnt   <= '0;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: begin
          if (nib_done) begin
            cnt      <= '0;
            state    <= next_state;
            lane_out <= next_lane;
            if (state == S_CHK) frame_count <= frame_count + 16'd1;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_laser_tx_scheduler.sv
// Self-checking bench: a queue-of-nibbles model predicts every output each cycle.
module tb_laser_tx_scheduler;

  localparam int NIB = 2;
  localparam int GAP = 4;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b1;
  logic [7:0]  ch0_data = '0;
  logic        ch0_valid = 1'b0;
  logic        ch0_ready;
  logic [7:0]  ch1_data = '0;
  logic        ch1_valid = 1'b0;
  logic        ch1_ready;
  logic [3:0]  lane_out;
  logic        busy;
  logic        last_grant;
  logic [15:0] frame_count;

  always #5 clock = ~clock;

  laser_tx_scheduler #(.NIBBLE_CLKS(NIB), .GAP_CLKS(GAP), .PREAMBLE(4'hA)) dut (
    .clock(clock), .reset(reset), .enable(enable),
    .ch0_data(ch0_data), .ch0_valid(ch0_valid), .ch0_ready(ch0_ready),
    .ch1_data(ch1_data), .ch1_valid(ch1_valid), .ch1_ready(ch1_ready),
    .lane_out(lane_out), .busy(busy), .last_grant(last_grant),
    .frame_count(frame_count)
  );

  typedef struct { logic [3:0] nib; bit inc; } ent_t;

  int          vectors = 0;
  int          errors  = 0;
  ent_t        mq[$];
  logic        m_last = 1'b1;
  logic [15:0] m_fc = '0;
  bit          chk_en = 1'b0;
  bit          acc0, acc1;
  bit          dut_r0, dut_r1;
  logic [3:0]  lane_log[$];
  int          grant_log[$];

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push_frame(input bit ch, input logic [7:0] d);
    logic [3:0] n[5];
    logic [3:0] hdr;
    ent_t e;
    hdr  = 4'(4 + 2 * ch + ($countones(d) % 2));
    n[0] = 4'hA;
    n[1] = hdr;
    n[2] = 4'(d / 16);
    n[3] = 4'(d % 16);
    n[4] = hdr ^ n[2] ^ n[3];
    for (int i = 0; i < 5; i++)
      for (int k = 0; k < NIB; k++) begin
        e.nib = n[i];
        e.inc = (i == 4 && k == NIB - 1);
        mq.push_back(e);
      end
    for (int g = 0; g < GAP; g++) begin
      e.nib = 4'h0;
      e.inc = 1'b0;
      mq.push_back(e);
    end
  endtask

  // One clock cycle: compare at negedge, advance the model at posedge.
  task automatic step();
    bit   idle, ok, r0, r1;
    ent_t e;
    @(negedge clock);
    idle = (mq.size() == 0);
    ok   = idle && enable && !reset;
    r0   = ok && ch0_valid && (!ch1_valid || m_last);
    r1   = ok && ch1_valid && (!ch0_valid || !m_last);
    if (chk_en) begin
      check("ch0_ready", 16'(ch0_ready), 16'(r0));
      check("ch1_ready", 16'(ch1_ready), 16'(r1));
      check("lane_out", 16'(lane_out), idle ? 16'h0 : 16'(mq[0].nib));
      check("busy", 16'(busy), 16'(!idle));
      check("last_grant", 16'(last_grant), 16'(m_last));
      check("frame_count", frame_count, m_fc);
    end
    dut_r0 = ch0_ready;
    dut_r1 = ch1_ready;
    lane_log.push_back(lane_out);
    acc0 = r0;
    acc1 = r1;
    @(posedge clock);
    if (reset) begin
      mq.delete();
      m_last = 1'b1;
      m_fc   = '0;
    end else begin
      if (mq.size() != 0) begin
        e = mq.pop_front();
        if (e.inc) m_fc++;
      end
      if (r0 || r1) begin
        m_last = r1;
        push_frame(r1, r1 ? ch1_data : ch0_data);
        grant_log.push_back(r1 ? 1 : 0);
      end
    end
    #1;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic check_frame(input string name, input int idx, input logic [3:0] n[5]);
    for (int i = 0; i < 5; i++)
      for (int k = 0; k < NIB; k++)
        check(name, 16'(lane_log[idx + 1 + i * NIB + k]), 16'(n[i]));
    for (int g = 0; g < GAP; g++)
      check(name, 16'(lane_log[idx + 1 + 5 * NIB + g]), 16'h0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    int idx, idx0, n, rcount;
    logic [3:0] f[5];

    // Reset then idle.
    #1;
    steps(2);
    reset  = 1'b0;
    chk_en = 1'b1;
    steps(20);
    check("reset_fc", frame_count, 16'h0);
    check("reset_last", 16'(last_grant), 16'h1);
    check("reset_lane", 16'(lane_out), 16'h0);

    // ch0 sends 8'h3C.
    ch0_data = 8'h3C; ch0_valid = 1'b1;
    step();
    idx = lane_log.size() - 1;
    ch0_valid = 1'b0;
    steps(5 * NIB + GAP + 1);
    f = '{4'hA, 4'h4, 4'h3, 4'hC, 4'hB};
    check_frame("frame_3c", idx, f);
    check("fc_after_3c", frame_count, 16'h1);
    check("last_after_3c", 16'(last_grant), 16'h0);

    // ch0 sends 8'h01 (odd parity).
    ch0_data = 8'h01; ch0_valid = 1'b1;
    step();
    idx = lane_log.size() - 1;
    ch0_valid = 1'b0;
    steps(5 * NIB + GAP + 1);
    f = '{4'hA, 4'h5, 4'h0, 4'h1, 4'h4};
    check_frame("frame_01", idx, f);

    // Contention: ch0 first (last_grant reset-relative), then ch1 15 cycles later.
    reset = 1'b1; step(); reset = 1'b0; step();
    ch0_data = 8'h3C; ch0_valid = 1'b1;
    ch1_data = 8'h81; ch1_valid = 1'b1;
    step();
    check("contend_first_ch0", 16'(dut_r0), 16'h1);
    idx0 = lane_log.size() - 1;
    ch0_valid = 1'b0;
    n = 0;
    for (int i = 1; i <= 40; i++) begin
      step();
      if (acc1) begin n = i; break; end
    end
    check("ch1_latency", 16'(n), 16'd15);
    idx = lane_log.size() - 1;
    ch1_valid = 1'b0;
    steps(5 * NIB + GAP + 1);
    f = '{4'hA, 4'h4, 4'h3, 4'hC, 4'hB};
    check_frame("contend_ch0", idx0, f);
    f = '{4'hA, 4'h6, 4'h8, 4'h1, 4'hF};
    check_frame("contend_ch1", idx, f);

    // Continuous requests alternate.
    grant_log.delete();
    ch0_valid = 1'b1; ch1_valid = 1'b1;
    for (int i = 0; i < 100 && grant_log.size() < 4; i++) step();
    ch0_valid = 1'b0; ch1_valid = 1'b0;
    for (int i = 0; i < 4; i++)
      check("alternate", (i < grant_log.size()) ? 16'(grant_log[i]) : 16'hFFFF, 16'(i % 2));
    steps(5 * NIB + GAP + 1);

    // enable dropped during DHI.
    ch0_data = 8'h5A; ch0_valid = 1'b1;
    step();
    ch0_valid = 1'b0;
    steps(5);
    enable = 1'b0; ch0_valid = 1'b1; ch1_valid = 1'b1;
    rcount = 0;
    for (int i = 0; i < 25; i++) begin
      step();
      rcount += int'(dut_r0) + int'(dut_r1);
    end
    check("no_ready_disabled", 16'(rcount), 16'h0);
    check("busy_after_disabled_frame", 16'(busy), 16'h0);
    enable = 1'b1;
    step();
    check("regrant_ch1", 16'(dut_r1), 16'h1);
    ch0_valid = 1'b0; ch1_valid = 1'b0;
    steps(5 * NIB + GAP + 1);

    // Reset during DLO.
    ch0_data = 8'hC3; ch0_valid = 1'b1;
    step();
    ch0_valid = 1'b0;
    steps(7);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("rst_mid_lane", 16'(lane_out), 16'h0);
    check("rst_mid_busy", 16'(busy), 16'h0);
    check("rst_mid_last", 16'(last_grant), 16'h1);
    check("rst_mid_fc", frame_count, 16'h0);
    ch0_data = 8'h3C; ch0_valid = 1'b1;
    step();
    idx = lane_log.size() - 1;
    ch0_valid = 1'b0;
    steps(5 * NIB + GAP + 1);
    f = '{4'hA, 4'h4, 4'h3, 4'hC, 4'hB};
    check_frame("frame_after_rst", idx, f);

    // Randomized traffic; valid normally held until accepted.
    for (int i = 0; i < 3000; i++) begin
      if (ch0_valid && !acc0) begin
        if ($urandom_range(99) < 3) ch0_valid = 1'b0;
      end else begin
        ch0_valid = ($urandom_range(99) < 40);
        ch0_data  = 8'($urandom);
      end
      if (ch1_valid && !acc1) begin
        if ($urandom_range(99) < 3) ch1_valid = 1'b0;
      end else begin
        ch1_valid = ($urandom_range(99) < 40);
        ch1_data  = 8'($urandom);
      end
      enable = ($urandom_range(99) < 85);
      reset  = ($urandom_range(299) == 0);
      step();
    end
    reset = 1'b0; ch0_valid = 1'b0; ch1_valid = 1'b0;
    steps(20);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
